// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter in front of a single-port data memory.
//                Round-robin between a core port (0) and a debug/loader
//                port (1), optional per-port lock with a forced-release
//                timeout, and a registered response one cycle after accept.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    // port 0: core load/store
    input  logic              r0_req_valid_i,
    output logic              r0_req_ready_o,
    input  logic              r0_we_i,
    input  logic              r0_lock_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    output logic              r0_rsp_valid_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    // port 1: debug/loader
    input  logic              r1_req_valid_i,
    output logic              r1_req_ready_o,
    input  logic              r1_we_i,
    input  logic              r1_lock_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_rsp_valid_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    // memory side
    output logic              mem_wr_en_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // status
    output logic              lock_timeout_o
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               timeout_q, timeout_d;

    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic [DATA_W-1:0]  r0_rdata_q;
    logic [DATA_W-1:0]  r1_rdata_q;

    logic               grant0;
    logic               grant1;
    logic               accept;
    logic               win;
    logic               win_we;
    logic               win_lock;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    // Grant decode; held off while reset is asserted so all outputs are 0.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (r0_req_valid_i && r1_req_valid_i) begin
                    grant0 = ~rr_ptr_q;
                    grant1 = rr_ptr_q;
                end else begin
                    grant0 = r0_req_valid_i;
                    grant1 = r1_req_valid_i;
                end
            end
            ST_LOCK0: grant0 = r0_req_valid_i;
            ST_LOCK1: grant1 = r1_req_valid_i;
            default: ;
        endcase
        if (rst) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    assign accept    = grant0 | grant1;
    assign win       = grant1;
    assign win_we    = win ? r1_we_i    : r0_we_i;
    assign win_lock  = win ? r1_lock_i  : r0_lock_i;
    assign win_addr  = win ? r1_addr_i  : r0_addr_i;
    assign win_wdata = win ? r1_wdata_i : r0_wdata_i;

    assign r0_req_ready_o = grant0;
    assign r1_req_ready_o = grant1;

    // Memory drive: winner's request on accept, everything quiet otherwise.
    assign mem_wr_en_o = accept &  win_we;
    assign mem_rd_en_o = accept & ~win_we;
    assign mem_addr_o  = accept ? win_addr  : '0;
    assign mem_wdata_o = accept ? win_wdata : '0;

    // Next-state logic: round-robin pointer, lock entry/exit and lock timer.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rr_ptr_d = ~win;
                    if (win_lock) begin
                        state_d    = win ? ST_LOCK1 : ST_LOCK0;
                        lock_cnt_d = CNT_W'(1);
                    end
                end
            end
            ST_LOCK0: begin
                if (!r0_lock_i) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == CNT_W'(LOCK_MAX)) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                    timeout_d  = 1'b1;
                    rr_ptr_d   = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            ST_LOCK1: begin
                if (!r1_lock_i) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == CNT_W'(LOCK_MAX)) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                    timeout_d  = 1'b1;
                    rr_ptr_d   = 1'b0;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 1'b0;
            lock_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Response capture: read data is sampled at the edge ending the accept
    // cycle; each port's rdata holds until that port's next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_id_q <= win;
                if (win) begin
                    r1_rdata_q <= win_we ? '0 : mem_rdata_i;
                end else begin
                    r0_rdata_q <= win_we ? '0 : mem_rdata_i;
                end
            end
        end
    end

    assign r0_rsp_valid_o = rsp_valid_q & ~rsp_id_q;
    assign r1_rsp_valid_o = rsp_valid_q &  rsp_id_q;
    assign r0_rdata_o     = r0_rdata_q;
    assign r1_rdata_o     = r1_rdata_q;
    assign lock_timeout_o = timeout_q;

endmodule
`default_nettype wire
